// File: rtl/fifo_pkg.sv
// Shared FIFO constants and wrap-bit pointer compare helpers.
package fifo_pkg;

   localparam int unsigned FIFO_DATA_WIDTH = 8;
   localparam int unsigned FIFO_DEPTH      = 8;
   // Widest pointer the helpers accept; callers zero-extend into this width.
   localparam int unsigned PTR_MAX         = 32;

   // Full when the wrap bits differ and the index bits below position aw match.
   function automatic logic ptr_full(input logic [PTR_MAX-1:0] wr,
                                     input logic [PTR_MAX-1:0] rd,
                                     input int unsigned        aw);
      logic [PTR_MAX-1:0] diff;
      logic [PTR_MAX-1:0] mask;
      diff = wr ^ rd;
      mask = (PTR_MAX'(1) << aw) - PTR_MAX'(1);
      return (((diff >> aw) & PTR_MAX'(1)) == PTR_MAX'(1)) && ((diff & mask) == '0);
   endfunction

   function automatic logic ptr_empty(input logic [PTR_MAX-1:0] wr,
                                      input logic [PTR_MAX-1:0] rd);
      return wr == rd;
   endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Incrementing FIFO pointer with enable; the top bit acts as the lap (wrap) flag.
module fifo_ptr #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   output logic [WIDTH-1:0] ptr_o
);

   logic [WIDTH-1:0] ptr_d;
   logic [WIDTH-1:0] ptr_q;

   always_comb begin
      ptr_d = ptr_q;
      if (en_i) begin
         ptr_d = ptr_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/sync_fifo_msb.sv
// Single-clock byte FIFO; full/empty derived from wrap-bit pointers, registered read data.
module sync_fifo_msb
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int unsigned DEPTH      = FIFO_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  full,
   output logic                  empty
);

   localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
   localparam int unsigned PTR_W      = ADDR_WIDTH + 1;

   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic                  wr_acc;
   logic                  rd_acc;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q;

   assign full   = ptr_full(PTR_MAX'(wr_ptr), PTR_MAX'(rd_ptr), ADDR_WIDTH);
   assign empty  = ptr_empty(PTR_MAX'(wr_ptr), PTR_MAX'(rd_ptr));
   assign wr_acc = wr_en && !full;
   assign rd_acc = rd_en && !empty;

   fifo_ptr #(.WIDTH(PTR_W)) u_wr_ptr (
      .clk   (clk),
      .rst_n (rst),
      .en_i  (wr_acc),
      .ptr_o (wr_ptr)
   );

   fifo_ptr #(.WIDTH(PTR_W)) u_rd_ptr (
      .clk   (clk),
      .rst_n (rst),
      .en_i  (rd_acc),
      .ptr_o (rd_ptr)
   );

   // Storage is deliberately left unreset; only the read register clears.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data_q <= '0;
      end else begin
         if (wr_acc) begin
            mem_q[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
         end
         if (rd_acc) begin
            rd_data_q <= mem_q[rd_ptr[ADDR_WIDTH-1:0]];
         end
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: tb/tb_sync_fifo_msb.sv
// Scoreboard bench for sync_fifo_msb: reset, fill, overflow, drain, wrap and async reset.
module tb_sync_fifo_msb;

   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0;
   logic          rd_en = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic [DW-1:0] rd_data;
   logic          full;
   logic          empty;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] model_q [$];
   logic [DW-1:0] exp_q   [$];
   logic [DW-1:0] last_rd = '0;

   sync_fifo_msb #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .rd_en   (rd_en),
      .wr_data (wr_data),
      .rd_data (rd_data),
      .full    (full),
      .empty   (empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock of stimulus; the reference model decides acceptance from pre-edge occupancy.
   task automatic drive(input logic w, input logic r, input logic [DW-1:0] d);
      logic wa;
      logic ra;
      wa = w && (model_q.size() < DEPTH);
      ra = r && (model_q.size() != 0);
      wr_en   = w;
      rd_en   = r;
      wr_data = d;
      if (ra) exp_q.push_back(model_q.pop_front());
      if (wa) model_q.push_back(d);
      @(posedge clk);
      @(negedge clk);
      wr_en = 1'b0;
      rd_en = 1'b0;
      if (ra) begin
         if (exp_q.size() != 0) last_rd = exp_q.pop_front();
      end
      chk("rd_data", 32'(rd_data), 32'(last_rd));
      chk("empty", 32'(empty), 32'(model_q.size() == 0));
      chk("full", 32'(full), 32'(model_q.size() == DEPTH));
   endtask

   logic [DW-1:0] fill_vals [DEPTH] = '{8'h50, 8'hA9, 8'hF0, 8'hEF, 8'h3F, 8'hE9, 8'h01, 8'hFF};

   initial begin
      // Reset held low for a cycle
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_rd_data", 32'(rd_data), 32'h00);
      rst = 1'b1;
      @(negedge clk);
      drive(1'b0, 1'b1, 8'h00);

      // Fill to full
      for (int i = 0; i < int'(DEPTH); i++) drive(1'b1, 1'b0, fill_vals[i]);

      // Overflow attempts are dropped
      drive(1'b1, 1'b0, 8'h6C);
      drive(1'b1, 1'b0, 8'hAC);

      // Drain in order, then reads while empty hold the last word
      for (int i = 0; i < int'(DEPTH); i++) drive(1'b0, 1'b1, 8'h00);
      drive(1'b0, 1'b1, 8'h00);
      drive(1'b0, 1'b1, 8'h00);
      chk("hold_ff", 32'(rd_data), 32'hFF);

      // Mid-occupancy streaming across several pointer laps
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, DW'($urandom));
      for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, DW'($urandom));
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 8'h00);

      // Simultaneous request on empty: write only
      drive(1'b1, 1'b1, 8'h5A);
      drive(1'b0, 1'b1, 8'h00);

      // Async reset between edges with 3 entries held
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, DW'(8'h10 + i));
      #2 rst = 1'b0;
      #1;
      chk("async_empty", 32'(empty), 32'd1);
      chk("async_full", 32'(full), 32'd0);
      chk("async_rd_data", 32'(rd_data), 32'h00);
      model_q.delete();
      exp_q.delete();
      last_rd = '0;
      @(negedge clk);
      rst = 1'b1;
      drive(1'b1, 1'b0, 8'hC3);
      drive(1'b0, 1'b1, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
